// File: rtl/memory_bank.sv
// rtl/memory_bank.sv - DEPTH x WIDTH scratch bank with registered read port and bulk-clear sequencer.
// Optional macro READ_BYPASS_EN: same-address store+read returns the new data (write-first).
module memory_bank #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  data,
  input  logic              store,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              clear,
  output logic [WIDTH-1:0]  q,
  output logic              q_valid,
  output logic              busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
`ifdef READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  state_t            state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
      ptr     <= '0;
      state   <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            // clear takes priority: any store/read in this cycle is dropped
            state   <= CLEAR;
            ptr     <= '0;
            busy    <= 1'b1;
            q_valid <= 1'b0;
          end else begin
            if (store) mem[addr] <= data;
            q_valid <= rd_en;
            if (rd_en) begin
              if (BYPASS && store && (addr == raddr)) q <= data;
              else                                    q <= mem[raddr];
            end
          end
        end
        CLEAR: begin
          mem[ptr] <= '0;
          q_valid  <= 1'b0;
          // the sweep ends on the last entry, so ptr never wraps
          if (ptr == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bank.sv
// tb/tb_memory_bank.sv - randomized and directed checks of memory_bank against a behavioural model.
module tb_memory_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = '0;
  logic       store = 1'b0;
  logic [1:0] addr = '0;
  logic       rd_en = 1'b0;
  logic [1:0] raddr = '0;
  logic       clear = 1'b0;
  logic [7:0] q;
  logic       q_valid;
  logic       busy;

  logic [15:0] data1 = '0;
  logic        store1 = 1'b0;
  logic [3:0]  addr1 = '0;
  logic        rd_en1 = 1'b0;
  logic [3:0]  raddr1 = '0;
  logic        clear1 = 1'b0;
  logic [15:0] q1;
  logic        q_valid1;
  logic        busy1;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_mem [4];
  logic [7:0] m_q;
  logic       m_qv;
  int         m_left;

`ifdef READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 clk = ~clk;

  memory_bank dut (
    .clk(clk), .reset(reset), .data(data), .store(store), .addr(addr),
    .rd_en(rd_en), .raddr(raddr), .clear(clear),
    .q(q), .q_valid(q_valid), .busy(busy)
  );

  memory_bank #(.WIDTH(16), .DEPTH(16), .ADDR_W(4)) dut16 (
    .clk(clk), .reset(reset), .data(data1), .store(store1), .addr(addr1),
    .rd_en(rd_en1), .raddr(raddr1), .clear(clear1),
    .q(q1), .q_valid(q_valid1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = '0;
    m_q = '0;
    m_qv = 1'b0;
    m_left = 0;
  endtask

  task automatic step(input logic st, input logic [1:0] a, input logic [7:0] d,
                      input logic re, input logic [1:0] ra, input logic cl);
    logic [7:0] old;
    @(negedge clk);
    store = st; addr = a; data = d; rd_en = re; raddr = ra; clear = cl;
    @(posedge clk);
    if (m_left > 0) begin
      m_mem[4 - m_left] = '0;
      m_left--;
      m_qv = 1'b0;
    end else if (cl) begin
      m_left = 4;
      m_qv = 1'b0;
    end else begin
      old = m_mem[ra];
      if (st) m_mem[a] = d;
      m_qv = re;
      if (re) m_q = (BYPASS && st && a == ra) ? d : old;
    end
    #1;
    check("q", 32'(q), 32'(m_q));
    check("q_valid", 32'(q_valid), 32'(m_qv));
    check("busy", 32'(busy), 32'(m_left > 0));
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] ra);
    step(1'b0, 2'd0, 8'h00, 1'b1, ra, 1'b0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(1'b1, a, d, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic step16(input logic st, input logic [3:0] a, input logic [15:0] d,
                        input logic re, input logic [3:0] ra, input logic cl);
    @(negedge clk);
    store1 = st; addr1 = a; data1 = d; rd_en1 = re; raddr1 = ra; clear1 = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // asynchronous reset with no clock edge
    for (int i = 0; i < 4; i++) wr(2'(i), 8'(8'h90 + i));
    rd(2'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_q", 32'(q), 32'h0);
    check("async_rst_qv", 32'(q_valid), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i));
      check("rst_read", 32'(q), 32'h0);
    end

    // write all, read back in reverse
    for (int i = 0; i < 4; i++) wr(2'(i), 8'(8'h11 * (i + 1)));
    for (int i = 3; i >= 0; i--) begin
      rd(2'(i));
      check("wr_rd", 32'(q), 32'(8'h11 * (i + 1)));
    end
    idle();
    check("hold_q", 32'(q), 32'h11);
    check("hold_qv", 32'(q_valid), 32'h0);

    // bulk clear with dropped store/read while busy
    for (int i = 0; i < 4; i++) wr(2'(i), 8'hFF);
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);
    cnt = 0;
    if (busy) begin
      cnt++;
      step(1'b1, 2'd1, 8'hAA, 1'b1, 2'd1, 1'b0);
      check("busy_rd_qv", 32'(q_valid), 32'h0);
    end
    while (busy && cnt < 20) begin
      cnt++;
      idle();
    end
    check("clear_cycles", 32'(cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i));
      check("after_clear", 32'(q), 32'h0);
    end

    // clear and store in the same cycle: clear wins
    step(1'b1, 2'd3, 8'h66, 1'b1, 2'd3, 1'b1);
    repeat (4) idle();
    rd(2'd3);
    check("clear_beats_store", 32'(q), 32'h0);

    // same-cycle store and read to one address
    wr(2'd2, 8'h5A);
    step(1'b1, 2'd2, 8'hC3, 1'b1, 2'd2, 1'b0);
    check("collision", 32'(q), BYPASS ? 32'hC3 : 32'h5A);
    rd(2'd2);
    check("collision_after", 32'(q), 32'hC3);

    // reset during the clear sweep
    for (int i = 0; i < 4; i++) wr(2'(i), 8'h77);
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);
    idle();
    idle();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check("midclear_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i));
      check("midclear_read", 32'(q), 32'h0);
    end

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0));
    end
    while (m_left > 0) idle();
    for (int i = 0; i < 4; i++) rd(2'(i));

    // 16 x 16 configuration
    step16(1'b1, 4'd15, 16'hBEEF, 1'b0, 4'd0, 1'b0);
    step16(1'b1, 4'd0, 16'h1234, 1'b0, 4'd0, 1'b0);
    step16(1'b0, 4'd0, 16'h0, 1'b1, 4'd15, 1'b0);
    check("w16_rd15", 32'(q1), 32'hBEEF);
    check("w16_qv", 32'(q_valid1), 32'h1);
    step16(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 1'b0);
    check("w16_rd0", 32'(q1), 32'h1234);
    step16(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1);
    cnt = 0;
    while (busy1 && cnt < 40) begin
      cnt++;
      step16(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
    end
    check("w16_clear_cycles", 32'(cnt), 32'd16);
    step16(1'b0, 4'd0, 16'h0, 1'b1, 4'd15, 1'b0);
    check("w16_after_clear", 32'(q1), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
